xswitch_port_scheduler: RTL and testbench

//  Per-output-port packet scheduler for the xswitch crossbar. Shares one switch output

---
 rtl/xswitch_port_scheduler.sv | 151 +++++++++++++++
 tb/tb_xswitch_port_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xswitch_port_scheduler.sv
// Round-robin, packet-granular scheduler for one xswitch output port.
// Holds a grant for a whole packet, counts accepted beats, then re-arbitrates.
module xswitch_port_scheduler #(
  parameter int NUM_REQ = 8,
  parameter int LEN_W   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     beat_last,
  output logic                     abort_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [NUM_REQ-1:0]   grant_r, grant_s;
  logic [ID_W-1:0]      grant_id_r, grant_id_s;
  logic [LEN_W-1:0]     rem_r, rem_s;
  logic [ID_W-1:0]      ptr_r, ptr_s;
  logic                 abort_r, abort_s;
  logic [ID_W-1:0]      pick_ptr_s;
  logic [ID_W:0]        pick_s;
  logic                 arb_s;
  logic                 abort_now_s;
  logic                 end_pkt_s;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    logic [ID_W-1:0] nxt;
    if (idx == ID_W'(NUM_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + ID_W'(1'b1);
    end
    return nxt;
  endfunction

  // Returns {found, index}: first requester scanning from p upward with wrap.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [ID_W-1:0]    p);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = p;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
      cand = next_idx(cand);
    end
    return {found, idx};
  endfunction

  function automatic logic [LEN_W-1:0] eff_len(input logic [NUM_REQ*LEN_W-1:0] lens,
                                               input logic [ID_W-1:0]          idx);
    logic [LEN_W-1:0] l;
    l = lens[int'(idx)*LEN_W +: LEN_W];
    return (l == '0) ? LEN_W'(1'b1) : l;
  endfunction

  // Next-state: beat counting, packet end / abort detection and re-arbitration.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    grant_id_s  = grant_id_r;
    rem_s       = rem_r;
    ptr_s       = ptr_r;
    abort_s     = 1'b0;
    pick_ptr_s  = ptr_r;
    arb_s       = 1'b0;
    abort_now_s = 1'b0;
    end_pkt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arb_s = |req;
      end
      ST_BUSY: begin
        abort_now_s = ~req[grant_id_r];
        end_pkt_s   = abort_now_s | ((rem_r == LEN_W'(1'b1)) & out_ready);
        if (end_pkt_s) begin
          abort_s    = abort_now_s;
          ptr_s      = next_idx(grant_id_r);
          pick_ptr_s = ptr_s;
          arb_s      = 1'b1;
        end else if (out_ready) begin
          rem_s = rem_r - LEN_W'(1'b1);
        end else begin
          rem_s = rem_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
    pick_s = rr_pick(req, pick_ptr_s);
    // Abort or finished packet with nobody waiting falls back to idle.
    if (arb_s && pick_s[ID_W]) begin
      state_s    = ST_BUSY;
      grant_id_s = pick_s[ID_W-1:0];
      grant_s    = NUM_REQ'(1'b1) << pick_s[ID_W-1:0];
      rem_s      = eff_len(req_len, pick_s[ID_W-1:0]);
    end else if (arb_s) begin
      state_s = ST_IDLE;
      grant_s = '0;
      rem_s   = '0;
    end else begin
      state_s = state_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      grant_id_r <= '0;
      rem_r      <= '0;
      ptr_r      <= '0;
      abort_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      grant_id_r <= grant_id_s;
      rem_r      <= rem_s;
      ptr_r      <= ptr_s;
      abort_r    <= abort_s;
    end
  end

  assign grant     = grant_r;
  assign grant_id  = grant_id_r;
  assign busy      = (state_r == ST_BUSY);
  assign beat_last = (state_r == ST_BUSY) && (rem_r == LEN_W'(1'b1));
  assign abort_err = abort_r;

endmodule

// File: tb/tb_xswitch_port_scheduler.sv
// Self-checking bench for xswitch_port_scheduler: directed scenarios then
// random traffic, all compared against a packet-level reference model.
module tb_xswitch_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [31:0] req_len;
  logic        out_ready;
  logic [7:0]  grant;
  logic [2:0]  grant_id;
  logic        busy;
  logic        beat_last;
  logic        abort_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: who holds the port and how many beats are left.
  int m_busy, m_id, m_rem, m_ptr, m_abort;

  xswitch_port_scheduler #(.NUM_REQ(8), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_len   (req_len),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .beat_last (beat_last),
    .abort_err (abort_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    logic [15:0] dbl;
    dbl = {r, r};
    for (int j = 0; j < 8; j++) begin
      if (dbl[p + j]) return (p + j) % 8;
    end
    return -1;
  endfunction

  function automatic int len_of(input int i);
    int v;
    v = (req_len >> (i * 4)) & 15;
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_rem = 0; m_ptr = 0; m_abort = 0;
  endtask

  task automatic model_step();
    int nid;
    int ab;
    ab = 0;
    if (m_busy == 0) begin
      if (req != 8'h00) begin
        m_id = pick(req, m_ptr); m_rem = len_of(m_id); m_busy = 1;
      end
    end else if (!req[m_id] || (m_rem == 1 && out_ready)) begin
      if (!req[m_id]) ab = 1;
      m_ptr = (m_id + 1) % 8;
      nid = pick(req, m_ptr);
      if (nid >= 0) begin
        m_id = nid; m_rem = len_of(nid);
      end else begin
        m_busy = 0;
      end
    end else if (out_ready) begin
      m_rem = m_rem - 1;
    end
    m_abort = ab;
  endtask

  task automatic compare_all();
    logic [7:0] one;
    one = 8'h01;
    check("grant", grant, (m_busy != 0) ? (one << m_id) : 8'h00);
    check("busy", busy, m_busy);
    check("beat_last", beat_last, (m_busy != 0 && m_rem == 1) ? 1 : 0);
    check("abort_err", abort_err, m_abort);
    if (m_busy != 0) check("grant_id", grant_id, m_id);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; req = 8'h00; req_len = 32'h0; out_ready = 1'b1;
    model_reset();
    #1;
    check("rst_grant", grant, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_abort", abort_err, 1'b0);
    #1;
    reset = 1'b0;

    // Every requester, single-beat packets: round-robin 0..7 then 0.
    req = 8'hFF; req_len = 32'h1111_1111; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      check("rr_id", grant_id, k % 8);
      check("rr_busy", busy, 1'b1);
    end
    req = 8'h00;
    cycle(); cycle();

    // One four-beat packet from requester 3.
    req = 8'h08; req_len = 32'h0000_4000;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("pkt4_grant", grant, 8'h08);
      check("pkt4_last", beat_last, (c == 3) ? 1'b1 : 1'b0);
      if (c == 3) req = 8'h00;
    end
    cycle();
    check("pkt4_idle_grant", grant, 8'h00);
    check("pkt4_idle_busy", busy, 1'b0);

    // Three-beat packet with stalls between beats.
    req = 8'h01; req_len = 32'h0000_0003;
    cycle();
    for (int c = 0; c < 5; c++) begin
      check("stall_grant", grant, 8'h01);
      out_ready = (c % 2 == 0);
      if (c == 4) req = 8'h00;
      cycle();
    end
    check("stall_end_busy", busy, 1'b0);
    out_ready = 1'b1;
    cycle();

    // Reset in the middle of a packet with three beats left.
    req = 8'h02; req_len = 32'h0000_0050;
    cycle(); cycle(); cycle();
    check("mid_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst_grant", grant, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_last", beat_last, 1'b0);
    model_reset();
    req = 8'h00;
    @(negedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // Requester 0 drops its request after two beats; grant passes to 2.
    req = 8'h05; req_len = 32'h0000_0505;
    cycle();
    check("abort_first", grant, 8'h01);
    cycle(); cycle();
    req = 8'h04;
    cycle();
    check("abort_pulse", abort_err, 1'b1);
    check("abort_move", grant, 8'h04);
    cycle();
    check("abort_once", abort_err, 1'b0);
    req = 8'h00;
    cycle(); cycle();

    // Random traffic: sticky requests, occasional drops, random stalls.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) req[i] = ($urandom_range(99) >= 4);
        else        req[i] = ($urandom_range(99) < 25);
      end
      req_len   = $urandom();
      out_ready = ($urandom_range(3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
